axi3_burst_master: RTL

Command-driven AXI3 master sequencer that converts one simple burst command at a time into a complete AXI3 write (AW, W, B) or read (AR, R) transaction. It drives the same AXI3 slave port set as the BFM path into the DUT, so a directed-test front end or DMA-style engine can reach the DUT without the BFM. It issues single-outstanding INCR bursts, streams write data from a show-ahead source FIFO, and returns read data plus a completion status.

---
 rtl/axi3_burst_master.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi3_burst_master.sv
// Command-driven AXI3 master: turns one burst command at a time into a single
// outstanding INCR write (AW/W/B) or read (AR/R) transaction with a completion status.
module axi3_burst_master #(
    parameter int AXI_DW = 64,
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 8,
    parameter int MST_ID = 0
) (
    input  logic                  axi_clk_i,
    input  logic                  axi_rstn_i,
    // command side
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [AXI_AW-1:0]     cmd_addr_i,
    input  logic [3:0]            cmd_len_i,
    input  logic [AXI_DW-1:0]     wr_data_i,
    output logic                  wr_pop_o,
    output logic [AXI_DW-1:0]     rd_data_o,
    output logic                  rd_valid_o,
    output logic                  done_o,
    output logic [1:0]            resp_o,
    // AXI3 write address
    output logic [AXI_IW-1:0]     axi_awid_i,
    output logic [AXI_AW-1:0]     axi_awaddr_i,
    output logic [3:0]            axi_awlen_i,
    output logic [2:0]            axi_awsize_i,
    output logic [1:0]            axi_awburst_i,
    output logic [1:0]            axi_awlock_i,
    output logic [3:0]            axi_awcache_i,
    output logic [2:0]            axi_awprot_i,
    output logic                  axi_awvalid_i,
    input  logic                  axi_awready_o,
    // AXI3 write data
    output logic [AXI_IW-1:0]     axi_wid_i,
    output logic [AXI_DW-1:0]     axi_wdata_i,
    output logic [AXI_DW/8-1:0]   axi_wstrb_i,
    output logic                  axi_wlast_i,
    output logic                  axi_wvalid_i,
    input  logic                  axi_wready_o,
    // AXI3 write response
    input  logic [1:0]            axi_bresp_o,
    input  logic                  axi_bvalid_o,
    output logic                  axi_bready_i,
    // AXI3 read address
    output logic [AXI_IW-1:0]     axi_arid_i,
    output logic [AXI_AW-1:0]     axi_araddr_i,
    output logic [3:0]            axi_arlen_i,
    output logic [2:0]            axi_arsize_i,
    output logic [1:0]            axi_arburst_i,
    output logic [1:0]            axi_arlock_i,
    output logic [3:0]            axi_arcache_i,
    output logic [2:0]            axi_arprot_i,
    output logic                  axi_arvalid_i,
    input  logic                  axi_arready_o,
    // AXI3 read data
    input  logic [AXI_DW-1:0]     axi_rdata_o,
    input  logic [1:0]            axi_rresp_o,
    input  logic                  axi_rlast_o,
    input  logic                  axi_rvalid_o,
    output logic                  axi_rready_i
);

    localparam int AXI_SW = AXI_DW / 8;
    localparam int SW_LG  = $clog2(AXI_SW);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_ERR
    } state_t;

    state_t              state_reg;
    logic [AXI_AW-1:0]   addr_reg;
    logic [3:0]          len_reg;
    logic [3:0]          cnt_reg;
    logic                awvalid_reg;
    logic                arvalid_reg;
    logic                wlast_reg;
    logic                done_reg;
    logic [1:0]          resp_reg;
    logic [1:0]          acc_reg;
    logic                ovf_reg;

    logic [AXI_AW-1:0]   cmd_addr_al;
    logic [15:0]         end_off;
    logic                crosses_4k;
    logic [1:0]          r_acc_next;
    logic                r_len_bad;
    logic [1:0]          r_final;

    assign cmd_addr_al = cmd_addr_i & ~AXI_AW'(AXI_SW - 1);
    // Offset just past the last byte within the 4KB page; beyond 4096 means the burst crosses it.
    assign end_off     = 16'(cmd_addr_al[11:0]) + ((16'(cmd_len_i) + 16'd1) << SW_LG);
    assign crosses_4k  = (end_off > 16'd4096);

    assign r_acc_next  = (axi_rresp_o > acc_reg) ? axi_rresp_o : acc_reg;
    assign r_len_bad   = ovf_reg || (cnt_reg != len_reg);
    assign r_final     = (r_len_bad && (r_acc_next < 2'b10)) ? 2'b10 : r_acc_next;

    always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
        if (!axi_rstn_i) begin
            state_reg   <= S_IDLE;
            addr_reg    <= '0;
            len_reg     <= '0;
            cnt_reg     <= '0;
            awvalid_reg <= 1'b0;
            arvalid_reg <= 1'b0;
            wlast_reg   <= 1'b0;
            done_reg    <= 1'b0;
            resp_reg    <= 2'b00;
            acc_reg     <= 2'b00;
            ovf_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        addr_reg <= cmd_addr_al;
                        len_reg  <= cmd_len_i;
                        if (crosses_4k) begin
                            state_reg <= S_ERR;
                        end else if (cmd_write_i) begin
                            state_reg   <= S_AW;
                            awvalid_reg <= 1'b1;
                        end else begin
                            state_reg   <= S_AR;
                            arvalid_reg <= 1'b1;
                        end
                    end
                end
                S_AW: begin
                    if (axi_awready_o) begin
                        awvalid_reg <= 1'b0;
                        cnt_reg     <= '0;
                        wlast_reg   <= (len_reg == 4'd0);
                        state_reg   <= S_W;
                    end
                end
                S_W: begin
                    if (axi_wready_o) begin
                        cnt_reg   <= cnt_reg + 4'd1;
                        wlast_reg <= ((cnt_reg + 4'd1) == len_reg);
                        if (wlast_reg) begin
                            wlast_reg <= 1'b0;
                            state_reg <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (axi_bvalid_o) begin
                        resp_reg  <= axi_bresp_o;
                        done_reg  <= 1'b1;
                        state_reg <= S_IDLE;
                    end
                end
                S_AR: begin
                    if (axi_arready_o) begin
                        arvalid_reg <= 1'b0;
                        cnt_reg     <= '0;
                        acc_reg     <= 2'b00;
                        ovf_reg     <= 1'b0;
                        state_reg   <= S_R;
                    end
                end
                S_R: begin
                    if (axi_rvalid_o) begin
                        if (axi_rlast_o) begin
                            resp_reg  <= r_final;
                            done_reg  <= 1'b1;
                            state_reg <= S_IDLE;
                        end else begin
                            acc_reg <= r_acc_next;
                            // Counter saturates at len; the sticky flag remembers the overrun.
                            if (cnt_reg == len_reg) begin
                                ovf_reg <= 1'b1;
                            end else begin
                                cnt_reg <= cnt_reg + 4'd1;
                            end
                        end
                    end
                end
                S_ERR: begin
                    resp_reg  <= 2'b10;
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready_o   = (state_reg == S_IDLE);
    assign axi_wvalid_i  = (state_reg == S_W);
    assign axi_bready_i  = (state_reg == S_B);
    assign axi_rready_i  = (state_reg == S_R);
    assign wr_pop_o      = axi_wvalid_i & axi_wready_o;
    assign rd_valid_o    = axi_rvalid_o & axi_rready_i;
    assign rd_data_o     = axi_rdata_o;
    assign done_o        = done_reg;
    assign resp_o        = resp_reg;

    assign axi_awid_i    = AXI_IW'(MST_ID);
    assign axi_awaddr_i  = addr_reg;
    assign axi_awlen_i   = len_reg;
    assign axi_awsize_i  = 3'(SW_LG);
    assign axi_awburst_i = 2'b01;
    assign axi_awlock_i  = 2'b00;
    assign axi_awcache_i = 4'b0000;
    assign axi_awprot_i  = 3'b000;
    assign axi_awvalid_i = awvalid_reg;

    assign axi_wid_i     = AXI_IW'(MST_ID);
    assign axi_wdata_i   = wr_data_i;
    assign axi_wstrb_i   = '1;
    assign axi_wlast_i   = wlast_reg;

    assign axi_arid_i    = AXI_IW'(MST_ID);
    assign axi_araddr_i  = addr_reg;
    assign axi_arlen_i   = len_reg;
    assign axi_arsize_i  = 3'(SW_LG);
    assign axi_arburst_i = 2'b01;
    assign axi_arlock_i  = 2'b00;
    assign axi_arcache_i = 4'b0000;
    assign axi_arprot_i  = 3'b000;
    assign axi_arvalid_i = arvalid_reg;

endmodule
